// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle: retiring instruction fields, decode read ports and
// writeback status outputs.
interface wb_regfile_if;
   logic        MEM_WB_reg_write_en;
   logic [1:0]  MEM_WB_reg_write_data_sel;
   logic [1:0]  MEM_WB_reg_dst;
   logic [2:0]  MEM_WB_rd;
   logic [15:0] MEM_WB_ex_res;
   logic [15:0] MEM_WB_data;
   logic [15:0] MEM_WB_pc_inc;
   logic        MEM_WB_alu_cond_out;
   logic        MEM_WB_halt;
   logic [2:0]  read1_reg;
   logic [2:0]  read2_reg;
   logic [15:0] read1_data;
   logic [15:0] read2_data;
   logic [15:0] wb_data;
   logic [2:0]  wb_reg;
   logic        wb_en;
   logic        halted;
   logic [15:0] commit_count;

   modport master (
      output MEM_WB_reg_write_en, MEM_WB_reg_write_data_sel, MEM_WB_reg_dst, MEM_WB_rd,
             MEM_WB_ex_res, MEM_WB_data, MEM_WB_pc_inc, MEM_WB_alu_cond_out, MEM_WB_halt,
             read1_reg, read2_reg,
      input  read1_data, read2_data, wb_data, wb_reg, wb_en, halted, commit_count
   );

   modport slave (
      input  MEM_WB_reg_write_en, MEM_WB_reg_write_data_sel, MEM_WB_reg_dst, MEM_WB_rd,
             MEM_WB_ex_res, MEM_WB_data, MEM_WB_pc_inc, MEM_WB_alu_cond_out, MEM_WB_halt,
             read1_reg, read2_reg,
      output read1_data, read2_data, wb_data, wb_reg, wb_en, halted, commit_count
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 8x16 architectural register file with same-cycle write
// bypass on both read ports, sticky halt and committed-write counter.
module wb_regfile (
   input  logic         clk,
   input  logic         rst,
   wb_regfile_if.slave  wb
);

   logic [15:0] regs [8];
   logic        halted_q;
   logic [15:0] commit_count_q;
   logic [15:0] wb_data;
   logic [2:0]  wb_reg;
   logic        wb_en;

   always_comb begin
      wb_data = wb.MEM_WB_ex_res;
      unique case (wb.MEM_WB_reg_write_data_sel)
         2'b00:   wb_data = wb.MEM_WB_ex_res;
         2'b01:   wb_data = wb.MEM_WB_data;
         2'b10:   wb_data = wb.MEM_WB_pc_inc;
         default: wb_data = {15'b0, wb.MEM_WB_alu_cond_out};
      endcase
   end

   // reg_dst 11 is the link form: destination is always R7
   assign wb_reg = (wb.MEM_WB_reg_dst == 2'b11) ? 3'd7 : wb.MEM_WB_rd;

   // rst gates the enable so a write presented on a reset edge is discarded
   assign wb_en = wb.MEM_WB_reg_write_en & ~halted_q & rst;

   assign wb.read1_data   = (wb_en && (wb_reg == wb.read1_reg)) ? wb_data : regs[wb.read1_reg];
   assign wb.read2_data   = (wb_en && (wb_reg == wb.read2_reg)) ? wb_data : regs[wb.read2_reg];
   assign wb.wb_data      = wb_data;
   assign wb.wb_reg       = wb_reg;
   assign wb.wb_en        = wb_en;
   assign wb.halted       = halted_q;
   assign wb.commit_count = commit_count_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         halted_q       <= 1'b0;
         commit_count_q <= '0;
      end else begin
         if (wb_en) begin
            regs[wb_reg]   <= wb_data;
            commit_count_q <= commit_count_q + 16'd1;
         end
         if (wb.MEM_WB_halt) halted_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed cases, random traffic and counter wrap
// checked against an array-based reference model.
module tb_wb_regfile;

   typedef struct packed {
      logic        rst_n;
      logic        we;
      logic [1:0]  sel;
      logic [1:0]  dst;
      logic [2:0]  rd;
      logic [15:0] ex;
      logic [15:0] data;
      logic [15:0] pc;
      logic        cond;
      logic        halt;
      logic [2:0]  r1;
      logic [2:0]  r2;
   } stim_t;

   typedef struct packed {
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic [15:0] wbd;
      logic [2:0]  wreg;
      logic        en;
      logic        halted;
      logic [15:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   wb_regfile_if bus ();

   wb_regfile dut (.clk(clk), .rst(rst), .wb(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb_q [$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_regs [8];
   logic        m_halted;
   logic [15:0] m_count;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle(input logic [2:0] r1, input logic [2:0] r2);
      stim_t s;
      s = '0;
      s.rst_n = 1'b1;
      s.r1 = r1;
      s.r2 = r2;
      return s;
   endfunction

   function automatic stim_t wr(input logic [2:0] rd, input logic [1:0] sel, input logic [15:0] v,
                                input logic [2:0] r1, input logic [2:0] r2);
      stim_t s;
      s = idle(r1, r2);
      s.we = 1'b1;
      s.rd = rd;
      s.sel = sel;
      s.ex = v;
      return s;
   endfunction

   // Apply one cycle of stimulus, queue the expected outputs, advance the model past the edge
   task automatic drive(input stim_t s);
      exp_t        e;
      logic [15:0] src;
      logic [2:0]  dest;
      logic        en;
      @(posedge clk);
      #1;
      rst                           = s.rst_n;
      bus.MEM_WB_reg_write_en       = s.we;
      bus.MEM_WB_reg_write_data_sel = s.sel;
      bus.MEM_WB_reg_dst            = s.dst;
      bus.MEM_WB_rd                 = s.rd;
      bus.MEM_WB_ex_res             = s.ex;
      bus.MEM_WB_data               = s.data;
      bus.MEM_WB_pc_inc             = s.pc;
      bus.MEM_WB_alu_cond_out       = s.cond;
      bus.MEM_WB_halt               = s.halt;
      bus.read1_reg                 = s.r1;
      bus.read2_reg                 = s.r2;

      case (s.sel)
         2'd0: src = s.ex;
         2'd1: src = s.data;
         2'd2: src = s.pc;
         default: src = s.cond ? 16'd1 : 16'd0;
      endcase
      dest = (s.dst == 2'd3) ? 3'd7 : s.rd;
      en   = s.we && !m_halted && s.rst_n;

      e.wbd    = src;
      e.wreg   = dest;
      e.en     = en;
      e.halted = m_halted;
      e.cnt    = m_count;
      e.rd1    = (en && dest == s.r1) ? src : m_regs[s.r1];
      e.rd2    = (en && dest == s.r2) ? src : m_regs[s.r2];
      sb_q.push_back(e);

      if (!s.rst_n) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
         m_halted = 1'b0;
         m_count  = 16'h0000;
      end else begin
         if (en) begin
            m_regs[dest] = src;
            m_count      = m_count + 16'd1;
         end
         if (s.halt) m_halted = 1'b1;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("read1_data",   bus.read1_data,          e.rd1);
            chk("read2_data",   bus.read2_data,          e.rd2);
            chk("wb_data",      bus.wb_data,             e.wbd);
            chk("wb_reg",       {13'b0, bus.wb_reg},     {13'b0, e.wreg});
            chk("wb_en",        {15'b0, bus.wb_en},      {15'b0, e.en});
            chk("halted",       {15'b0, bus.halted},     {15'b0, e.halted});
            chk("commit_count", bus.commit_count,        e.cnt);
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      rst = 1'b0;
      bus.MEM_WB_reg_write_en       = 1'b1;
      bus.MEM_WB_reg_write_data_sel = 2'd0;
      bus.MEM_WB_reg_dst            = 2'd0;
      bus.MEM_WB_rd                 = 3'd5;
      bus.MEM_WB_ex_res             = 16'hDEAD;
      bus.MEM_WB_data               = 16'h0;
      bus.MEM_WB_pc_inc             = 16'h0;
      bus.MEM_WB_alu_cond_out       = 1'b0;
      bus.MEM_WB_halt               = 1'b1;
      bus.read1_reg                 = 3'd0;
      bus.read2_reg                 = 3'd0;
      // First edge resets the DUT; model starts in the reset state
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_halted = 1'b0;
      m_count  = 16'h0000;

      for (int i = 0; i < 4; i++) drive(idle(3'(i), 3'(7 - i)));

      // Source select into R3
      s = wr(3'd3, 2'd0, 16'h1234, 3'd3, 3'd0); drive(s);
      s.sel = 2'd1; s.data = 16'hBEEF; drive(s);
      s.sel = 2'd2; s.pc = 16'h0042; drive(s);
      s.sel = 2'd3; s.cond = 1'b1; drive(s);
      drive(idle(3'd3, 3'd3));

      // Link write to R7 with same-cycle bypass; R2 untouched
      s = wr(3'd2, 2'd2, 16'h0, 3'd7, 3'd2); s.dst = 2'd3; s.pc = 16'h0100; drive(s);
      drive(idle(3'd7, 3'd2));

      drive(wr(3'd4, 2'd0, 16'h1111, 3'd4, 3'd4));
      // Halt retires with its own write; the following write is suppressed
      s = wr(3'd1, 2'd0, 16'hAAAA, 3'd1, 3'd1); s.halt = 1'b1; drive(s);
      drive(wr(3'd1, 2'd0, 16'h5555, 3'd1, 3'd1));
      drive(idle(3'd1, 3'd4));

      // Reset mid-operation with a write in flight
      s = wr(3'd4, 2'd0, 16'hFFFF, 3'd4, 3'd1); s.rst_n = 1'b0; drive(s);
      drive(idle(3'd4, 3'd1));

      for (int i = 0; i < 600; i++) begin
         s.rst_n = ($urandom_range(0, 49) != 0);
         s.we    = 1'($urandom);
         s.sel   = 2'($urandom);
         s.dst   = 2'($urandom);
         s.rd    = 3'($urandom);
         s.ex    = 16'($urandom);
         s.data  = 16'($urandom);
         s.pc    = 16'($urandom);
         s.cond  = 1'($urandom);
         s.halt  = ($urandom_range(0, 63) == 0);
         s.r1    = 3'($urandom);
         s.r2    = ($urandom_range(0, 3) == 0) ? s.rd : 3'($urandom);
         drive(s);
      end

      // Counter wrap: 65536 writes bring commit_count back to zero
      s = idle(3'd0, 3'd0); s.rst_n = 1'b0; drive(s);
      for (int i = 0; i < 65536; i++) begin
         s = wr(3'($urandom), 2'd0, 16'($urandom), 3'($urandom), 3'($urandom));
         drive(s);
      end
      drive(idle(3'd0, 3'd7));
      drive(idle(3'd1, 3'd2));

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the five-stage pipeline; consumes the MEM/WB pipeline register outputs and commits results. Selects the writeback value and destination register, writes the 8x16 register file, and serves two read ports to decode with same-cycle write bypass. Also latches a sticky halt on the retiring halt instruction and counts committed register writes for the bench.

## Interface
- No parameters: 8 registers x 16 bits, fixed.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets all state
- MEM_WB_reg_write_en  in  1  commit a register write this cycle
- MEM_WB_reg_write_data_sel  in  2  writeback source: 00 ex_res, 01 data, 10 pc_inc, 11 {15'b0, alu_cond_out}
- MEM_WB_reg_dst  in  2  destination select: 00/01/10 use MEM_WB_rd, 11 forces R7 (link)
- MEM_WB_rd  in  3  destination register index
- MEM_WB_ex_res  in  16  execute result
- MEM_WB_data  in  16  memory load data
- MEM_WB_pc_inc  in  16  PC+2 of the retiring instruction
- MEM_WB_alu_cond_out  in  1  condition/set result
- MEM_WB_halt  in  1  retiring instruction is HALT
- read1_reg, read2_reg  in  3 each  decode read indices
- read1_data, read2_data  out  16 each  combinational read data
- wb_data  out  16  selected writeback value (to forwarding network)
- wb_reg  out  3  resolved destination index
- wb_en  out  1  write actually performed this cycle
- halted  out  1  sticky halt flag
- commit_count  out  16  number of committed register writes

## Operation
- wb_data = mux of sources per reg_write_data_sel; combinational, always driven.
- wb_reg = (reg_dst==2'b11) ? 3'd7 : MEM_WB_rd.
- wb_en = MEM_WB_reg_write_en & ~halted & rst. Halt instruction itself may still write if reg_write_en=1 (halted not yet set).
- On rising edge with wb_en=1: regs[wb_reg] <= wb_data.
- Read ports: readN_data = (wb_en && wb_reg==readN_reg) ? wb_data : regs[readN_reg]. R0 is a normal register (no hardwired zero).
- halted: set at rising edge when MEM_WB_halt=1 and rst=1; never clears except by reset. Once halted, all writes suppressed and commit_count frozen.
- commit_count increments by 1 on each edge with wb_en=1; wraps 16'hFFFF -> 16'h0000.

## Timing
- Reset (rst=0 at edge): all 8 registers 16'h0000, halted=0, commit_count=0. While rst=0, wb_en=0 so no write can sneak in on the reset edge; read data reflects register contents (zero after first reset edge).
- Reset mid-operation: same cycle behaviour; in-flight write on that edge is discarded.
- Write latency: value visible on read ports in the same cycle via bypass, from the array the next cycle.
- Simultaneous: write and both reads to same index -> both ports return wb_data. Halt and write same cycle -> write commits, halted=1 next cycle.
- No handshake; one writeback per cycle, no stalls generated.

## Test plan
- Reset: drive rst=0 one edge, then read all 8 regs -> all 16'h0000, halted=0, commit_count=0.
- Source select: rd=3, write_en=1, sel=00/01/10/11 with ex_res=16'h1234, data=16'hBEEF, pc_inc=16'h0042, cond=1 on successive cycles -> R3 reads 1234, BEEF, 0042, 0001; commit_count=4.
- Link/bypass: reg_dst=11, rd=2, sel=10, pc_inc=16'h0100, read1_reg=7 same cycle -> read1_data=0100 immediately; R2 unchanged.
- Halt: write R1=16'hAAAA with halt=1, then write R1=16'h5555 -> R1=AAAA, halted=1, commit_count incremented once only.
- Reset mid-operation: rst=0 on edge with write_en=1 to R4=16'hFFFF -> R4=0000, commit_count=0; halted cleared if previously set.
- Wrap: 65536 consecutive writes -> commit_count returns to 16'h0000.
